// File: rtl/lsram_arb_pkg.sv
// ---------------------------------------------------------------------------
// lsram_arb_pkg
// Shared types and default widths for the LSRAM two-port arbiter.
//   owner_e   : arbiter state / winner of a cycle (idle, port A, port B)
//   rd_tag_t  : per-read tag carried alongside the RAM read latency
// ---------------------------------------------------------------------------
package lsram_arb_pkg;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_DATA_W   = 40;
  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  typedef struct packed {
    logic vld;
    logic own_b;
  } rd_tag_t;

endpackage

// File: rtl/lsram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// lsram_port_arbiter_if
// One requester command/response port of the LSRAM arbiter.
//   req/we/addr/wdata : command from requester (held stable until gnt)
//   gnt               : command accepted this cycle
//   rvalid/rdata      : read data returned to the issuing port
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface lsram_port_arbiter_if
  import lsram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsram_arb_rdpipe.sv
// ---------------------------------------------------------------------------
// lsram_arb_rdpipe
// RD_LAT-deep shift register of read tags that tracks which port issued each
// accepted read, so the RAM read data can be steered back to it.
//   HCLK, HRESETN        : clock, async active-low clear (drops in-flight tags)
//   i_tag                : {vld, own_b} of this cycle's accepted read
//   a_rvalid, b_rvalid   : one-cycle strobes when the RAM data belongs to A / B
// ---------------------------------------------------------------------------
module lsram_arb_rdpipe
  import lsram_arb_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic    HCLK,
  input  logic    HRESETN,
  input  rd_tag_t i_tag,
  output logic    a_rvalid,
  output logic    b_rvalid
);

  rd_tag_t r_pipe [RD_LAT];

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign a_rvalid = r_pipe[RD_LAT-1].vld & ~r_pipe[RD_LAT-1].own_b;
  assign b_rvalid = r_pipe[RD_LAT-1].vld &  r_pipe[RD_LAT-1].own_b;

endmodule

// File: rtl/lsram_port_arbiter.sv
// ---------------------------------------------------------------------------
// lsram_port_arbiter
// Shares one registered-read LSRAM port between requester A (AHB side) and
// requester B (loader/scrubber). Round-robin with a bounded hold window;
// at most one command accepted per cycle, driven to the RAM the same cycle.
//   HCLK, HRESETN      : clock, async active-low reset
//   a_if, b_if         : requester ports (slave modport)
//   mem_blk_en/mem_wen : RAM read / write enable for the accepted command
//   mem_addr/mem_wdata : RAM address / write data (hold last value when idle)
//   mem_rdata          : RAM read data, returned RD_LAT cycles after the read
//
// state    | meaning
// OWN_IDLE | nothing accepted last cycle
// OWN_A    | port A won last cycle
// OWN_B    | port B won last cycle
// ---------------------------------------------------------------------------
module lsram_port_arbiter
  import lsram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                HCLK,
  input  logic                HRESETN,
  lsram_port_arbiter_if.slave a_if,
  lsram_port_arbiter_if.slave b_if,
  output logic                mem_blk_en,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int              HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  owner_e              r_state;
  owner_e              w_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_rr_b;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_wdata;
  logic                w_a_req;
  logic                w_b_req;
  logic                w_both;
  logic                w_hold_ok;
  rd_tag_t             w_rd_tag;
  logic                w_a_rvalid;
  logic                w_b_rvalid;

  // Requests are masked while reset is held so no grant or RAM strobe can
  // escape combinationally during reset.
  assign w_a_req   = a_if.req & HRESETN;
  assign w_b_req   = b_if.req & HRESETN;
  assign w_both    = w_a_req & w_b_req;
  assign w_hold_ok = (r_hold_cnt < HOLD_LIM);

  // State register, hold counter and round-robin pointer
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state    <= OWN_IDLE;
      r_hold_cnt <= '0;
      r_rr_b     <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != OWN_IDLE) && (w_next == r_state)) begin
        if (r_hold_cnt != HOLD_LIM) r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
      // Pointer goes to whoever lost a contested cycle.
      if (w_both) r_rr_b <= (w_next == OWN_A);
    end
  end

  // Next-state (winner of this cycle)
  always_comb begin
    w_next = OWN_IDLE;
    case (r_state)
      OWN_A: begin
        if (w_a_req && (!w_b_req || w_hold_ok)) w_next = OWN_A;
        else if (w_b_req)                       w_next = OWN_B;
      end
      OWN_B: begin
        if (w_b_req && (!w_a_req || w_hold_ok)) w_next = OWN_B;
        else if (w_a_req)                       w_next = OWN_A;
      end
      default: begin
        if (w_both)       w_next = r_rr_b ? OWN_B : OWN_A;
        else if (w_a_req) w_next = OWN_A;
        else if (w_b_req) w_next = OWN_B;
      end
    endcase
  end

  // Outputs: grants and RAM command mux
  always_comb begin
    a_if.gnt   = (w_next == OWN_A);
    b_if.gnt   = (w_next == OWN_B);
    mem_wen    = 1'b0;
    mem_blk_en = 1'b0;
    mem_addr   = r_last_addr;
    mem_wdata  = r_last_wdata;
    case (w_next)
      OWN_A: begin
        mem_wen    = a_if.we;
        mem_blk_en = ~a_if.we;
        mem_addr   = a_if.addr;
        mem_wdata  = a_if.wdata;
      end
      OWN_B: begin
        mem_wen    = b_if.we;
        mem_blk_en = ~b_if.we;
        mem_addr   = b_if.addr;
        mem_wdata  = b_if.wdata;
      end
      default: ;
    endcase
  end

  // Last accepted address/data, presented to the RAM while idle
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else if (w_next != OWN_IDLE) begin
      r_last_addr  <= mem_addr;
      r_last_wdata <= mem_wdata;
    end
  end

  assign w_rd_tag.vld   = mem_blk_en;
  assign w_rd_tag.own_b = (w_next == OWN_B);

  lsram_arb_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .i_tag    (w_rd_tag),
    .a_rvalid (w_a_rvalid),
    .b_rvalid (w_b_rvalid)
  );

  assign a_if.rvalid = w_a_rvalid;
  assign b_if.rvalid = w_b_rvalid;
  assign a_if.rdata  = w_a_rvalid ? mem_rdata : '0;
  assign b_if.rdata  = w_b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_lsram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsram_port_arbiter
// Directed bench for lsram_port_arbiter with a behavioural 1-cycle
// registered-read RAM attached to the mem_* port.
// ---------------------------------------------------------------------------
module tb_lsram_port_arbiter;
  import lsram_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 40;

  logic          HCLK    = 1'b0;
  logic          HRESETN = 1'b0;
  logic          mem_blk_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [2048];
  logic [DW-1:0] r_ram_q;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DW-1:0] D010 = 40'h11_2233_4455;
  localparam logic [DW-1:0] D001 = 40'h01_0000_00A1;
  localparam logic [DW-1:0] D002 = 40'h02_0000_00B2;
  localparam logic [DW-1:0] D7FF = 40'hAB_DEAD_BEEF;

  lsram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  lsram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

  lsram_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_LAT   (1),
    .MAX_HOLD (4)
  ) dut (
    .HCLK       (HCLK),
    .HRESETN    (HRESETN),
    .a_if       (a_if),
    .b_if       (b_if),
    .mem_blk_en (mem_blk_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (mem_wen)    ram[mem_addr] <= mem_wdata;
    if (mem_blk_en) r_ram_q <= ram[mem_addr];
  end
  assign mem_rdata = r_ram_q;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int run;
    int max_run;
    logic last_a;

    ram[11'h010] = D010;
    ram[11'h001] = D001;
    ram[11'h002] = D002;
    r_ram_q      = '0;
    drv_a(1'b1, 1'b0, 11'h010, '0);
    drv_b(1'b0, 1'b0, '0, '0);

    // Reset: outputs quiet even with a request pending
    smp();
    chk("rst_a_gnt",    a_if.gnt,    0);
    chk("rst_b_gnt",    b_if.gnt,    0);
    chk("rst_blk_en",   mem_blk_en,  0);
    chk("rst_wen",      mem_wen,     0);
    chk("rst_addr",     mem_addr,    0);
    chk("rst_wdata",    mem_wdata,   0);
    chk("rst_a_rvalid", a_if.rvalid, 0);

    // Test 1: lone A read
    nxt();
    HRESETN = 1'b1;
    smp();
    chk("t1_a_gnt",  a_if.gnt,   1);
    chk("t1_b_gnt",  b_if.gnt,   0);
    chk("t1_blk_en", mem_blk_en, 1);
    chk("t1_wen",    mem_wen,    0);
    chk("t1_addr",   mem_addr,   11'h010);
    nxt();
    drv_a(1'b0, 1'b0, '0, '0);
    smp();
    chk("t1_a_rvalid", a_if.rvalid, 1);
    chk("t1_a_rdata",  a_if.rdata,  D010);
    chk("t1_b_rvalid", b_if.rvalid, 0);
    nxt();
    smp();
    chk("t1_rvalid_1cyc", a_if.rvalid, 0);
    chk("t1_blk_idle",    mem_blk_en,  0);
    chk("t1_addr_hold",   mem_addr,    11'h010);

    // Test 2: B write then read at top address
    nxt();
    drv_b(1'b1, 1'b1, 11'h7FF, D7FF);
    smp();
    chk("t2_wr_gnt",   b_if.gnt,   1);
    chk("t2_wen",      mem_wen,    1);
    chk("t2_wr_blk",   mem_blk_en, 0);
    chk("t2_wr_addr",  mem_addr,   11'h7FF);
    chk("t2_wr_wdata", mem_wdata,  D7FF);
    nxt();
    drv_b(1'b1, 1'b0, 11'h7FF, '0);
    smp();
    chk("t2_rd_gnt", b_if.gnt,   1);
    chk("t2_rd_blk", mem_blk_en, 1);
    nxt();
    drv_b(1'b0, 1'b0, '0, '0);
    smp();
    chk("t2_b_rvalid", b_if.rvalid, 1);
    chk("t2_b_rdata",  b_if.rdata,  D7FF);
    chk("t2_a_rvalid", a_if.rvalid, 0);
    chk("t2_a_rdata",  a_if.rdata,  0);
    nxt();
    smp();

    // Test 4: simultaneous rise from IDLE twice
    nxt();
    drv_a(1'b1, 1'b0, 11'h001, '0);
    drv_b(1'b1, 1'b0, 11'h002, '0);
    smp();
    chk("t4_first_a_gnt", a_if.gnt, 1);
    chk("t4_first_b_gnt", b_if.gnt, 0);
    nxt();
    drv_a(1'b0, 1'b0, '0, '0);
    smp();
    chk("t4_b_follow_gnt", b_if.gnt,   1);
    chk("t4_a_rvalid",     a_if.rvalid, 1);
    chk("t4_a_rdata",      a_if.rdata,  D001);
    nxt();
    drv_b(1'b0, 1'b0, '0, '0);
    smp();
    chk("t4_b_rvalid", b_if.rvalid, 1);
    chk("t4_b_rdata",  b_if.rdata,  D002);
    nxt();
    drv_a(1'b1, 1'b0, 11'h001, '0);
    drv_b(1'b1, 1'b0, 11'h002, '0);
    smp();
    chk("t4_second_b_gnt", b_if.gnt, 1);
    chk("t4_second_a_gnt", a_if.gnt, 0);
    nxt();
    drv_b(1'b0, 1'b0, '0, '0);
    smp();
    chk("t4_a_follow_gnt", a_if.gnt, 1);
    nxt();
    drv_a(1'b0, 1'b0, '0, '0);
    smp();

    // Test 3: both held high, hold window of 4
    nxt();
    drv_a(1'b1, 1'b0, 11'h001, '0);
    drv_b(1'b1, 1'b0, 11'h002, '0);
    run = 0;
    max_run = 0;
    last_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      smp();
      chk($sformatf("t3_a_gnt%0d", i), a_if.gnt, ((i / 4) % 2) == 0);
      chk($sformatf("t3_b_gnt%0d", i), b_if.gnt, ((i / 4) % 2) == 1);
      if (i == 0 || a_if.gnt != last_a) run = 1;
      else run++;
      last_a = a_if.gnt;
      if (run > max_run) max_run = run;
      nxt();
    end
    chk("t3_max_run", max_run, 4);
    drv_a(1'b0, 1'b0, '0, '0);
    drv_b(1'b0, 1'b0, '0, '0);
    smp();

    // Test 5: alternating single-port reads, one per cycle
    for (int i = 0; i < 9; i++) begin
      nxt();
      drv_a((i < 8) && (i % 2 == 0), 1'b0, 11'h001, '0);
      drv_b((i < 8) && (i % 2 == 1), 1'b0, 11'h002, '0);
      smp();
      if (i < 8) begin
        if (i % 2 == 0) chk($sformatf("t5_a_gnt%0d", i), a_if.gnt, 1);
        else            chk($sformatf("t5_b_gnt%0d", i), b_if.gnt, 1);
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk($sformatf("t5_a_rvalid%0d", i), a_if.rvalid, 1);
          chk($sformatf("t5_a_rdata%0d", i),  a_if.rdata,  D001);
          chk($sformatf("t5_b_quiet%0d", i),  b_if.rvalid, 0);
        end else begin
          chk($sformatf("t5_b_rvalid%0d", i), b_if.rvalid, 1);
          chk($sformatf("t5_b_rdata%0d", i),  b_if.rdata,  D002);
          chk($sformatf("t5_a_quiet%0d", i),  a_if.rvalid, 0);
        end
      end
    end

    // Test 6: reset while a read is in flight
    nxt();
    drv_a(1'b1, 1'b0, 11'h010, '0);
    smp();
    chk("t6_a_gnt", a_if.gnt, 1);
    #2;
    HRESETN = 1'b0;
    smp();
    chk("t6_rst_a_gnt",    a_if.gnt,    0);
    chk("t6_rst_b_gnt",    b_if.gnt,    0);
    chk("t6_rst_a_rvalid", a_if.rvalid, 0);
    chk("t6_rst_b_rvalid", b_if.rvalid, 0);
    chk("t6_rst_a_rdata",  a_if.rdata,  0);
    chk("t6_rst_blk_en",   mem_blk_en,  0);
    chk("t6_rst_wen",      mem_wen,     0);
    chk("t6_rst_addr",     mem_addr,    0);
    chk("t6_rst_wdata",    mem_wdata,   0);
    nxt();
    drv_a(1'b0, 1'b0, '0, '0);
    HRESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk($sformatf("t6_no_a_rvalid%0d", i), a_if.rvalid, 0);
      chk($sformatf("t6_no_b_rvalid%0d", i), b_if.rvalid, 0);
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
